// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its round-robin front end.
//   ALU_*        4-bit ALU operation codes, as decoded by the ALU datapath
//   arb_state_t  arbiter FSM state encoding
package alu_pkg;

  localparam logic [3:0] ALU_OR    = 4'b0000;
  localparam logic [3:0] ALU_AND   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_PASSA = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick.
//   req_i  request vector
//   ptr_i  highest-priority index for this pick
//   gnt_o  one-hot grant (all zero when no request)
//   idx_o  index of the granted bit (0 when no request)
//   any_o  at least one request present
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  int pos;

  // Scan upward from ptr_i, wrapping; first set bit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(ptr_i) + k) % NREQ;
      if (!any_o && req_i[pos]) begin
        any_o = 1'b1;
        idx_o = IDXW'(pos);
      end
    end
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end sharing one combinational ALU between NREQ requesters.
// One operation at a time: accept (IDLE) -> drive ALU (EXEC) -> hold response (RESP).
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        per-requester request handshake
//   req_a/req_b/req_op         packed per-requester operands and opcode
//   rsp_valid/rsp_ready        per-requester response handshake
//   rsp_data/rsp_zero/lt/gt    shared captured result and flags
//   alu_a/alu_b/alu_op         to the ALU
//   alu_d/alu_zero/lt/gt       from the ALU
//   busy, grant_id             status: not idle, current owner
//
//   state | meaning
//   IDLE  | waiting for a request; req_ready follows the round-robin pick
//   EXEC  | captured operands on the ALU; result sampled at the edge
//   RESP  | rsp_valid to the owner, held until its rsp_ready
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = 32,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*4-1:0] req_op,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_zero,
  output logic              rsp_lt,
  output logic              rsp_gt,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [3:0]        alu_op,
  input  logic [W-1:0]      alu_d,
  input  logic              alu_zero,
  input  logic              alu_lt,
  input  logic              alu_gt,
  output logic              busy,
  output logic [IDXW-1:0]   grant_id
);

  arb_state_t      state_q;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0] owner_q;
  logic [W-1:0]    a_q, b_q;
  logic [3:0]      op_q;
  logic [W-1:0]    rsp_data_q;
  logic            zero_q, lt_q, gt_q;
  logic [NREQ-1:0] rsp_valid_q;

  logic [NREQ-1:0] pick_gnt;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;

  rr_picker #(.NREQ(NREQ), .IDXW(IDXW)) u_picker (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    rr_ptr_d = (pick_idx == IDXW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      rsp_data_q  <= '0;
      zero_q      <= 1'b0;
      lt_q        <= 1'b0;
      gt_q        <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            a_q      <= req_a[pick_idx*W +: W];
            b_q      <= req_b[pick_idx*4*0 + pick_idx*W +: W];
            op_q     <= req_op[pick_idx*4 +: 4];
            owner_q  <= pick_idx;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q <= alu_d;
          zero_q     <= alu_zero;
          // The ALU leaves lt/gt stale when the operands are equal.
          if (a_q == b_q) begin
            lt_q <= 1'b0;
            gt_q <= 1'b0;
          end else begin
            lt_q <= alu_lt;
            gt_q <= alu_gt;
          end
          rsp_valid_q <= NREQ'(1) << owner_q;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner_q]) begin
            rsp_valid_q <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE) ? pick_gnt : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = zero_q;
  assign rsp_lt    = lt_q;
  assign rsp_gt    = gt_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = owner_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
module tb_alu_rr_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ*4-1:0] req_op;
  logic [NREQ-1:0] rsp_valid;
  logic [NREQ-1:0] rsp_ready = '0;
  logic [W-1:0]    rsp_data;
  logic            rsp_zero, rsp_lt, rsp_gt;
  logic [W-1:0]    alu_a, alu_b, alu_d;
  logic [3:0]      alu_op;
  logic            alu_zero;
  logic            alu_lt = 1'b0;
  logic            alu_gt = 1'b0;
  logic            busy;
  logic [1:0]      grant_id;

  alu_rr_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_lt(rsp_lt), .rsp_gt(rsp_gt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_d(alu_d), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_gt(alu_gt),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: undefined codes act as ADD; lt/gt stay stale on equality.
  always @* begin
    logic [W-1:0] d;
    case (alu_op)
      ALU_OR:    d = alu_a | alu_b;
      ALU_AND:   d = alu_a & alu_b;
      ALU_XOR:   d = alu_a ^ alu_b;
      ALU_SUB:   d = alu_a - alu_b;
      ALU_SLT:   d = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      ALU_PASSA: d = alu_a;
      default:   d = alu_a + alu_b;
    endcase
    alu_d    = d;
    alu_zero = (d == '0);
    if (alu_a != alu_b) begin
      alu_lt = (alu_a < alu_b);
      alu_gt = (alu_a > alu_b);
    end
  end

  logic [W-1:0] ta [NREQ];
  logic [W-1:0] tb [NREQ];
  logic [3:0]   top[NREQ];

  always_comb begin
    req_a  = '0;
    req_b  = '0;
    req_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = ta[i];
      req_b[i*W +: W] = tb[i];
      req_op[i*4 +: 4] = top[i];
    end
  end

  typedef struct {
    int          id;
    logic [31:0] d;
    logic        z, lt, gt;
  } exp_t;

  exp_t etab[NREQ];
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [31:0] d,
                         input logic z, input logic lt, input logic gt);
    ta[i] = a; tb[i] = b; top[i] = op;
    etab[i].id = i; etab[i].d = d; etab[i].z = z; etab[i].lt = lt; etab[i].gt = gt;
  endtask

  // Waits for an accept, checks its grant, and queues the expected response.
  task automatic accept(input string name, input int exp_id);
    int id;
    id = -1;
    for (int k = 0; k < 40 && id < 0; k++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++)
        if (req_ready[i]) id = i;
    end
    if (id < 0) begin
      check({name, " accept timeout"}, 32'hFFFF_FFFF, 32'(exp_id));
    end else begin
      check({name, " grant"}, 32'(req_ready), 32'(1 << exp_id));
      sb.push_back(etab[id]);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, " drain"}, 32'(sb.size()) | 32'(busy), 32'd0);
  endtask

  // Monitor: compare on every completed response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if ((rsp_valid & rsp_ready) != '0) begin
        if (sb.size() == 0) begin
          check("unexpected rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_valid", 32'(rsp_valid), 32'(1 << e.id));
          check("grant_id", 32'(grant_id), 32'(e.id));
          check("rsp_data", rsp_data, e.d);
          check("rsp_flags", {29'd0, rsp_zero, rsp_lt, rsp_gt}, {29'd0, e.z, e.lt, e.gt});
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) set_req(i, '0, '0, ALU_OR, '0, 1'b1, 1'b0, 1'b0);
    do_reset();

    // Reset state
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst grant_id", 32'(grant_id), 32'd0);
    check("rst alu_a", alu_a, 32'd0);
    check("rst alu_op", 32'(alu_op), 32'd0);
    check("rst rsp_data", rsp_data, 32'd0);

    // 1: single ADD, latency and return to IDLE
    set_req(0, 32'd5, 32'd3, ALU_ADD, 32'd8, 1'b0, 1'b0, 1'b1);
    req_valid = 4'b0001;
    accept("t1", 0);
    req_valid = '0;
    check("t1 exec rsp_valid", 32'(rsp_valid), 32'd0);
    check("t1 exec busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("t1 resp rsp_valid", 32'(rsp_valid), 32'b0001);
    rsp_ready = 4'b0001;
    @(posedge clk); #1;
    check("t1 idle busy", 32'(busy), 32'd0);
    drain("t1");

    // 2: all valid, rotation 0,1,2,3,0; equal operands clear lt/gt
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'd7, 32'd7, ALU_SUB, 32'd0, 1'b1, 1'b0, 1'b0);
    rsp_ready = 4'b1111;
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) accept("t2", n % 4);
    req_valid = '0;
    drain("t2");

    // 3: stalled response for requester 2; others must not be accepted
    rsp_ready = '0;
    set_req(2, 32'd1, 32'd2, ALU_SLT, 32'd1, 1'b0, 1'b1, 1'b0);
    set_req(1, 32'h1234, 32'd0, ALU_PASSA, 32'h1234, 1'b0, 1'b0, 1'b1);
    req_valid = 4'b0100;
    accept("t3", 2);
    req_valid = 4'b0010;
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      rsp_ready = (k % 2 == 1) ? 4'b0010 : 4'b0000;
      #3;
      check("t3 stall rsp_valid", 32'(rsp_valid), 32'b0100);
      check("t3 stall rsp_data", rsp_data, 32'd1);
      check("t3 stall req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 4'b1111;
    accept("t3b", 1);
    req_valid = '0;
    drain("t3");

    // 4: requester 3 wraps the pointer; a pending 0 wins next
    set_req(3, 32'd10, 32'd4, ALU_SUB, 32'd6, 1'b0, 1'b0, 1'b1);
    set_req(0, 32'hF0, 32'hFF, ALU_XOR, 32'h0F, 1'b0, 1'b1, 1'b0);
    req_valid = 4'b1000;
    accept("t4", 3);
    req_valid = 4'b1001;
    accept("t4b", 0);
    req_valid = '0;
    drain("t4");

    // 5: reset during EXEC abandons the transaction
    set_req(2, 32'd3, 32'd3, ALU_OR, 32'd3, 1'b0, 1'b0, 1'b0);
    req_valid = 4'b0100;
    accept("t5", 2);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("t5 rst busy", 32'(busy), 32'd0);
    check("t5 rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5 rst grant_id", 32'(grant_id), 32'd0);
    check("t5 rst alu_a", alu_a, 32'd0);
    check("t5 rst req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5 no rsp", 32'(rsp_valid), 32'd0);
    set_req(1, 32'hC, 32'hA, ALU_AND, 32'h8, 1'b0, 1'b0, 1'b1);
    req_valid = 4'b0110;
    accept("t5b", 1);
    req_valid = '0;
    drain("t5");

    // 6: undefined opcode behaves as ADD and is passed through unmodified
    set_req(2, 32'hFFFF_FFFF, 32'd1, 4'b1010, 32'd0, 1'b1, 1'b0, 1'b1);
    req_valid = 4'b0100;
    accept("t6", 2);
    req_valid = '0;
    check("t6 alu_op", 32'(alu_op), 32'hA);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares the single combinational ALU between NREQ independent requesters, e.g. the pipeline EX stage, the address-generation unit and the debug port.
- Arbitration is round-robin. Each requester uses a valid/ready handshake on the request side and on the response side.
- The block registers the operands and opcode, drives the ALU inputs, captures the result and flags, and returns them to the granted requester.
- It sits between the requesters and the ALU instance. The ALU stays purely combinational.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, operand/result width; must match the ALU datapath.
- IDXW, $clog2(NREQ), requester index width (derived; not overridden).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester request accept; at most one bit high.
- req_a  in  NREQ*W  packed operand A; requester i occupies bits [i*W +: W].
- req_b  in  NREQ*W  packed operand B, same packing.
- req_op  in  NREQ*4  packed 4-bit ALU operation code.
- rsp_valid  out  NREQ  per-requester response valid; at most one bit high.
- rsp_ready  in  NREQ  per-requester response accept.
- rsp_data  out  W  result; shared bus, meaningful only where rsp_valid is high.
- rsp_zero, rsp_lt, rsp_gt  out  1 each  captured flags.
- alu_a, alu_b  out  W  to ALU regA/regB.
- alu_op  out  4  to ALU aluoperation.
- alu_d  in  W  from ALU regD.
- alu_zero, alu_lt, alu_gt  in  1 each  from ALU flags.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  IDXW  index of the current owner (valid while busy).

Behaviour:

Reset (async, rst_n=0) clears:
- state=IDLE, rr_ptr=0, owner=0.
- Operand/op registers = 0, so alu_a=alu_b=0 and alu_op=4'b0000.
- rsp_data=0, rsp_zero=rsp_lt=rsp_gt=0.
- req_ready=0, rsp_valid=0, busy=0, grant_id=0.
- A reset asserted mid-operation abandons the transaction. No response is issued, and the requester must re-request.

FSM states: IDLE, EXEC, RESP.

IDLE:
- If req_valid != 0, the winner is the first set bit scanning upward from rr_ptr, wrapping modulo NREQ.
- req_ready[winner]=1 combinationally in this cycle.
- On the edge: capture req_a/req_b/req_op of the winner; owner<=winner; rr_ptr<=(winner+1) mod NREQ; go to EXEC.
- If no request is valid, stay in IDLE; rr_ptr is unchanged.

EXEC (exactly 1 cycle):
- alu_* are driven from the captured registers.
- On the edge: rsp_data<=alu_d; rsp_zero<=alu_zero.
- Flag override: if captured a==b, then rsp_lt<=0 and rsp_gt<=0 (the ALU holds stale lt/gt on equality). Otherwise rsp_lt<=alu_lt and rsp_gt<=alu_gt.
- Go to RESP.

RESP:
- rsp_valid[owner]=1; outputs are held stable.
- When rsp_ready[owner]=1 on an edge, go to IDLE. Otherwise hold indefinitely.
- rsp_ready bits of non-owners are ignored.

Ordering and throughput:
- req_ready is never asserted outside IDLE.
- Requests are not pipelined: minimum 3 cycles per operation, request accept to response accept.
- The latency from accept to rsp_valid is exactly 2 cycles.

Fairness and operand rules:
- With every requester continuously valid, grants rotate 0,1,2,...,NREQ-1,0,...
- A requester is starved by no more than NREQ-1 operations.
- alu_op is passed unmodified, including undefined codes (the ALU treats them as ADD).
- The arbiter performs no arithmetic apart from the W-bit equality compare used for the flag override.
- A requester may drop req_valid while not granted; it is not latched.
- req_a/b/op are sampled only in the accept cycle.

Decomposition:
- Package alu_pkg holds:
  - the ALU opcode constants: ALU_OR=4'b0000, ALU_AND=4'b0001, ALU_ADD=4'b0010, ALU_XOR=4'b0100, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_PASSA=4'b1111;
  - the typedef arb_state_t {IDLE, EXEC, RESP}.
- Sub-module rr_picker (parameter NREQ): combinational round-robin priority pick from req vector and ptr, producing a one-hot grant plus an index.
- The ALU itself is instantiated beside this block at the level above, not inside it.

Test Plan:
1. Reset, then req_valid=0001, a=5, b=3, op=ALU_ADD.
   - req_ready=0001 in the same cycle.
   - Two cycles later: rsp_valid=0001, rsp_data=8, zero=0, gt=1, lt=0.
   - rsp_ready=1 returns the block to IDLE, busy=0.
2. req_valid=1111 held, each requester issuing SUB with a=b=7.
   - Grant order is 0,1,2,3,0.
   - Every response has rsp_data=0, zero=1, lt=0, gt=0.
3. Requester 2 is granted (a=1, b=2, op=ALU_SLT), and rsp_ready is held 0 for 10 cycles.
   - rsp_valid stays 0100 with rsp_data=1, and no req_ready is asserted.
   - rsp_ready[1] pulses during the stall and are ignored.
4. rsp_ready high with a next request already valid: when requester 3 wins with rr_ptr wrapping, rr_ptr becomes 0. Then req_valid=1001 is presented and requester 0 wins.
5. Assert rst_n=0 during EXEC.
   - All outputs go to their reset values immediately (asynchronously), with no rsp_valid.
   - After release, a fresh request from requester 1 is granted first (rr_ptr=0 scans to 1).
6. Illegal op 4'b1010 with a=0xFFFF_FFFF, b=1: rsp_data=0, zero=1, gt=1, lt=0.
